// File: rtl/ctrl_tx_paridad_if.sv
// Word handshake plus serial-line outputs of the parity frame transmitter.
// master = word producer / line observer, slave = the transmitter itself.
interface ctrl_tx_paridad_if;
  logic [6:0] data;
  logic       parimpar;
  logic       valido;
  logic       listo;
  logic       tx;
  logic       paridad;
  logic       ocupado;

  modport master (
    output data, parimpar, valido,
    input  listo, tx, paridad, ocupado
  );

  modport slave (
    input  data, parimpar, valido,
    output listo, tx, paridad, ocupado
  );
endinterface

// File: rtl/ctrl_tx_paridad.sv
// Serial frame transmitter: start, 7 data bits LSB first, parity, stop; each bit held DIV cycles.
// Latency: first start bit one cycle after acceptance; listo low for 10*DIV cycles per frame.
module ctrl_tx_paridad #(
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ctrl_tx_paridad_if.slave    bus
);

  localparam int            CW       = $clog2(DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARIDAD,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          accept;
  logic          last;

  assign accept = bus.valido && (state_q == S_IDLE);
  assign last   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;

    if (state_q != S_IDLE) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = bus.data;
          par_d   = (^bus.data) ^ bus.parimpar;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) state_d = S_DATA;
      end
      S_DATA: begin
        if (last) begin
          if (bit_q == 3'd6) begin
            state_d = S_PARIDAD;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[6:1]};
          end
        end
      end
      S_PARIDAD: begin
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the upcoming state so the line never glitches
    case (state_d)
      S_START:   tx_d = 1'b0;
      S_DATA:    tx_d = shift_d[0];
      S_PARIDAD: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.listo   = (state_q == S_IDLE);
  assign bus.ocupado = (state_q != S_IDLE);
  assign bus.tx      = tx_q;
  assign bus.paridad = par_q;

endmodule

// File: tb/tb_ctrl_tx_paridad.sv
// Bench for ctrl_tx_paridad: DIV=4 and DIV=1 instances share stimulus, each tracked by a frame-level model.
module tb_ctrl_tx_paridad;

  localparam int DIVV [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] data_s = '0;
  logic       parimpar_s = 1'b0;
  logic       valido_s = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  ctrl_tx_paridad_if if4 ();
  ctrl_tx_paridad_if if1 ();

  assign if4.data     = data_s;
  assign if4.parimpar = parimpar_s;
  assign if4.valido   = valido_s;
  assign if1.data     = data_s;
  assign if1.parimpar = parimpar_s;
  assign if1.valido   = valido_s;

  ctrl_tx_paridad #(.DIV(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  ctrl_tx_paridad #(.DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  // Frame model: pos = cycles elapsed in the frame (-1 when idle), frame = the 10 line bits in send order
  int         pos    [2] = '{-1, -1};
  logic [9:0] frame  [2];
  logic       par_m  [2] = '{1'b0, 1'b0};

  logic smp_lst4, smp_par4, smp_par1, smp_tx1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic g_tx, g_listo, g_ocup, g_par, e_tx, e_listo;
    for (int i = 0; i < 2; i++) begin
      g_tx    = (i == 0) ? if4.tx      : if1.tx;
      g_listo = (i == 0) ? if4.listo   : if1.listo;
      g_ocup  = (i == 0) ? if4.ocupado : if1.ocupado;
      g_par   = (i == 0) ? if4.paridad : if1.paridad;
      e_listo = (pos[i] < 0);
      e_tx    = e_listo ? 1'b1 : frame[i][pos[i] / DIVV[i]];
      check($sformatf("tx_div%0d", DIVV[i]),      g_tx,    e_tx);
      check($sformatf("listo_div%0d", DIVV[i]),   g_listo, e_listo);
      check($sformatf("ocupado_div%0d", DIVV[i]), g_ocup,  !e_listo);
      check($sformatf("paridad_div%0d", DIVV[i]), g_par,   par_m[i]);
    end
    smp_lst4 = if4.listo;
    smp_par4 = if4.paridad;
    smp_par1 = if1.paridad;
    smp_tx1  = if1.tx;
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (pos[i] >= 0) begin
        pos[i]++;
        if (pos[i] == 10 * DIVV[i]) pos[i] = -1;
      end else if (valido_s) begin
        pos[i]   = 0;
        frame[i] = {1'b1, (^data_s) ^ parimpar_s, data_s, 1'b0};
        par_m[i] = (^data_s) ^ parimpar_s;
      end
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, then advance the model at the rising edge
  task automatic cycle(input logic v, input logic [6:0] d, input logic p);
    @(negedge clk);
    compare();
    valido_s   = v;
    data_s     = d;
    parimpar_s = p;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 7'h00, 1'b0);
  endtask

  task automatic send_measure(input string tag, input logic [6:0] d, input logic p, input logic exp_par);
    int low;
    low = 0;
    cycle(1'b1, d, p);
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, d, p);
      if (k == 0) check({tag, "_paridad"}, smp_par4, exp_par);
      if (smp_lst4) break;
      low++;
    end
    check({tag, "_listo_low_cycles"}, low, 40);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx4"},  if4.tx, 1'b1);
    check({tag, "_listo4"}, if4.listo, 1'b1);
    check({tag, "_ocupado4"}, if4.ocupado, 1'b0);
    check({tag, "_paridad4"}, if4.paridad, 1'b0);
    check({tag, "_tx1"},  if1.tx, 1'b1);
    check({tag, "_listo1"}, if1.listo, 1'b1);
  endtask

  initial begin
    int ones;
    logic [9:0] seq;

    #1 rst_n = 1'b0;
    #2 reset_checks("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    send_measure("w1000101_even", 7'b1000101, 1'b0, 1'b1);
    idle(2);
    send_measure("w1000101_odd",  7'b1000101, 1'b1, 1'b0);
    idle(2);
    send_measure("w1100110_even", 7'b1100110, 1'b0, 1'b0);
    idle(2);
    send_measure("w1100110_odd",  7'b1100110, 1'b1, 1'b1);
    idle(2);

    // valido held high across two frames, data disturbed while frame 1 is in flight
    cycle(1'b1, 7'b1111111, 1'b1);
    ones = 0;
    for (int k = 1; k <= 75; k++) begin
      cycle(1'b1, (k < 20) ? 7'b0000000 : 7'b1111111, 1'b1);
      if (k == 1) check("b2b_paridad_f1", smp_par4, 1'b0);
      if (smp_lst4) ones++;
    end
    check("b2b_idle_gap_cycles", ones, 1);
    check("b2b_paridad_f2", smp_par4, 1'b0);
    idle(50);

    // reset in the middle of data bit 3
    cycle(1'b1, 7'b1010011, 1'b1);
    for (int k = 0; k < 50; k++) begin
      if (pos[0] >= 0 && pos[0] / 4 == 4) break;
      cycle(1'b0, 7'h00, 1'b0);
    end
    check("pre_abort_tx", if4.tx, 1'b0);
    #2 rst_n = 1'b0;
    valido_s = 1'b0;
    #1 reset_checks("abort");
    pos   = '{-1, -1};
    par_m = '{1'b0, 1'b0};
    @(negedge clk);
    rst_n = 1'b1;
    send_measure("after_abort", 7'b0000001, 1'b0, 1'b1);
    idle(2);

    // DIV=1 frame captured bit by bit
    cycle(1'b1, 7'b0101010, 1'b0);
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 7'h00, 1'b0);
      seq[k] = smp_tx1;
      if (k == 0) check("div1_paridad", smp_par1, 1'b1);
    end
    check("div1_frame", seq, 10'b1101010100);
    idle(45);

    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 3) != 0, 7'($urandom), 1'($urandom));
    end
    idle(45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_tx_paridad.md
Name: ctrl_tx_paridad

Overview:
Serial frame controller that sequences the team's 7-bit parity generator. It accepts a 7-bit word plus a parity-mode select through a valid/ready handshake, then computes the parity bit internally (parimpar=0 even, parimpar=1 odd). It shifts out an asynchronous-serial frame: start bit, 7 data bits LSB first, parity bit, stop bit. It sits between the word producer and the serial line driver.

Parameters:
DIV, 4, clock cycles each frame bit is held on tx; legal range DIV >= 1; DIV < 1 is illegal (not checked in RTL).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
data  input  7  word to transmit, sampled only at acceptance
parimpar  input  1  parity mode, sampled only at acceptance: 0 = even (total ones incl. parity bit even), 1 = odd
valido  input  1  producer has a word on data/parimpar
listo  output  1  controller can accept a word this cycle
tx  output  1  serial line, idle high
paridad  output  1  parity bit of the frame in flight, registered at acceptance
ocupado  output  1  frame in progress; always equals !listo

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - tx=1, listo=1, ocupado=0, paridad=0.
  - State IDLE; bit counter, cycle counter and shift register cleared.
- Reset asserted mid-frame aborts the frame: tx returns to 1 at once. The word is lost; there is no resume.
- Handshake:
  - Acceptance = valido && listo at a rising clk edge.
  - listo=1 only in IDLE. valido may be held high.
  - data/parimpar changes after acceptance have no effect on the frame in flight.
- At acceptance:
  - Latch data into the shift register.
  - paridad <= (^data) ^ parimpar.
  - State -> START.
- States (all outputs registered):
  - IDLE: tx=1. On acceptance -> START.
  - START: tx=0 for DIV cycles -> DATA.
  - DATA: tx = current bit, LSB first; each bit held DIV cycles; after bit 6 -> PARIDAD.
  - PARIDAD: tx=paridad for DIV cycles -> STOP.
  - STOP: tx=1 for DIV cycles -> IDLE.
- Timing:
  - The first START cycle is the cycle after the acceptance edge. listo falls in that same cycle.
  - Frame occupies exactly 10*DIV cycles (START through STOP).
  - listo rises in the cycle after the last STOP cycle.
  - Minimum one IDLE cycle (tx=1) between back-to-back frames, so frame period is 10*DIV+1 cycles with valido held high.
- Counters:
  - Cycle counter width is clog2(DIV)+1 bits; it counts 0..DIV-1 and wraps to 0 on each bit boundary.
  - Bit counter is 3 bits, counting 0..6 in DATA.
  - DIV=1 gives one cycle per bit with no special-casing.
- paridad holds its value through IDLE until the next acceptance.
- valido low in IDLE: remain in IDLE, tx=1, no output change.

Test Plan:
- Reset, then drive DIV=4, data=1000101, parimpar=0, valido 1 cycle -> paridad=1. tx over 40 cycles, each level held 4 cycles: 0 | 1 0 1 0 0 0 1 | 1 | 1. listo low for exactly 40 cycles, then high.
- Same data, parimpar=1 -> paridad=0. Parity slot on tx is 0; all other frame bits are identical to the first scenario.
- data=1100110: parimpar=0 -> paridad=0, data slots 0 1 1 0 0 1 1; parimpar=1 -> paridad=1.
- data=1111111, parimpar=1, valido held high for two frames -> paridad=0 for both. Frames are separated by exactly one tx=1 IDLE cycle (period 41 cycles). data changed to 0000000 mid-frame -> frame 1 unaffected.
- rst_n pulled low during DATA bit 3 -> tx=1, listo=1, ocupado=0 immediately, without waiting for a clk edge. After release, a new word with data=0000001, parimpar=0 -> paridad=1 and a clean full frame is sent.
- DIV=1 build with data=0101010, parimpar=0 -> 10-cycle frame: tx = 0, 0 1 0 1 0 1 0, 1, 1 (parity bit 1).
